// File: rtl/data_mem.sv
// data_mem: single-port byte-lane-writable data memory with RISC-V
// load/store sizing, one-cycle registered response and fault reporting.
module data_mem #(
    parameter  int XLEN = 32,
    parameter  int SIZE = 4096,
    localparam int AW   = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            ack,
    output logic            fault
);

    // Word storage; contents survive reset on purpose.
    logic [XLEN-1:0] mem_q [SIZE/4];

    logic [AW-3:0]   idx;
    logic [1:0]      off;
    logic [1:0]      sz;
    logic            legal;
    logic            aligned;
    logic            ok;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] rd_sh;
    logic [XLEN-1:0] ld_val;

    logic            ack_q;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    assign idx = addr[AW-1:2];
    assign off = addr[1:0];
    assign sz  = funct3[1:0];

    // Decode legality, alignment, lane enables and the load result.
    always_comb begin
        // Stores: SB/SH/SW only. Loads: additionally LBU/LHU, but no "LWU".
        if (we) legal = !funct3[2] && (sz != 2'b11);
        else    legal = (sz != 2'b11) && !(funct3[2] && sz == 2'b10);

        case (sz)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !addr[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b0;
        endcase
        ok = legal && aligned;

        case (sz)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        wdata_sh = wdata << {off, 3'b000};

        rd_word = mem_q[idx];
        rd_sh   = rd_word >> {off, 3'b000};
        case (funct3)
            3'b000:  ld_val = {{(XLEN-8){rd_sh[7]}}, rd_sh[7:0]};
            3'b001:  ld_val = {{(XLEN-16){rd_sh[15]}}, rd_sh[15:0]};
            3'b010:  ld_val = rd_word;
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, rd_sh[7:0]};
            3'b101:  ld_val = {{(XLEN-16){1'b0}}, rd_sh[15:0]};
            default: ld_val = '0;
        endcase

        // Faults force zero, stores hold, good loads deliver.
        fault_d = req && !ok;
        rdata_d = rdata_q;
        if (req) begin
            if (!ok)     rdata_d = '0;
            else if (!we) rdata_d = ld_val;
        end
    end

    // Commit legal aligned stores lane by lane; requests during reset are dropped.
    always_ff @(posedge clk) begin
        if (!rst && req && we && ok) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    // One-stage response register; reset clears it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= req;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack   = ack_q;
    assign fault = fault_q;
    assign rdata = rdata_q;

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
Parameters:
REQ-001 The block SHALL have parameter XLEN, default 32, which sets the data word width in bits; only 32 is supported.
REQ-002 The block SHALL have parameter SIZE, default 4096, which sets the memory capacity in bytes; it SHALL be a power of two and at least 8.
REQ-003 The block SHALL derive AW = log2(SIZE) as the byte-address width.

Ports:
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 req  in  1  request strobe; one access is accepted per cycle when high.
REQ-007 we  in  1  1 = store, 0 = load; sampled with req.
REQ-008 funct3  in  3  RISC-V access size and sign field; sampled with req.
REQ-009 addr  in  AW  byte address; sampled with req.
REQ-010 wdata  in  XLEN  store data, right-aligned; sampled with req.
REQ-011 rdata  out  XLEN  load result, registered.
REQ-012 ack  out  1  completion pulse for an accepted request.
REQ-013 fault  out  1  the acknowledged request was misaligned or illegal; valid only while ack is high.

Function
REQ-014 Storage SHALL be SIZE/4 words of XLEN bits, indexed by addr[AW-1:2], and SHALL be writable per byte lane.
REQ-015 Legal loads SHALL be funct3 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; legal stores SHALL be 000 SB, 001 SH and 010 SW.
REQ-016 Any other funct3 value for the given we SHALL be illegal.
REQ-017 Alignment: halfword accesses SHALL require addr[0]=0; word accesses SHALL require addr[1:0]=00; byte accesses SHALL always be aligned.
REQ-018 Latency SHALL be fixed at one cycle: a request accepted at edge N SHALL produce ack=1 for exactly the cycle following edge N.
REQ-019 Requests SHALL be accepted every cycle with no stall, so back-to-back traffic produces back-to-back acks.
REQ-020 A legal, aligned store SHALL write wdata[7:0] (SB), wdata[15:0] (SH) or wdata[31:0] (SW) into the lanes selected by addr[1:0] at the accepting edge.
REQ-021 Lanes not selected by a store SHALL remain unchanged.
REQ-022 A store ack SHALL leave rdata unchanged and SHALL drive fault=0.
REQ-023 A legal, aligned load SHALL return the selected byte or halfword right-aligned in rdata, sign-extended for LB/LH and zero-extended for LBU/LHU; LW SHALL return the full word.
REQ-024 A misaligned or illegal request SHALL NOT modify memory, SHALL produce ack=1 with fault=1, and SHALL drive rdata=0.
REQ-025 Read-after-write: a load accepted the cycle after a store to the same word SHALL return the newly written data.
REQ-026 Same-edge conflicts cannot occur because the block has a single port.
REQ-027 rdata SHALL hold its last value whenever ack=0.
REQ-028 addr SHALL be fully decoded within AW bits, so there is no out-of-range condition; higher address bits are the caller's responsibility.
REQ-029 The block SHALL have no internal FSM beyond the one-stage ack/fault/rdata pipeline register.

Reset
REQ-030 While rst=1, ack, fault and rdata SHALL be 0 immediately, independent of clk.
REQ-031 A request presented while rst=1 SHALL be ignored: no write and no ack.
REQ-032 If rst asserts in the cycle after acceptance, the pending ack SHALL be suppressed; a store committed at the accepting edge SHALL remain in memory.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 After rst deasserts, the first req SHALL be accepted at the next rising edge.

Verification
REQ-035 SW 0xDEADBEEF at addr 0x10, then LW at 0x10 on the next cycle -> ack with rdata=0xDEADBEEF and fault=0, with no idle cycle between the two acks.
REQ-036 Continuing from REQ-035:
- LB at 0x13 -> 0xFFFFFFDE
- LBU at 0x13 -> 0x000000DE
- LH at 0x10 -> 0xFFFFBEEF
- LHU at 0x12 -> 0x0000DEAD
REQ-037 SB 0x12345677 at 0x11 over word 0xDEADBEEF, then LW 0x10 -> 0xDEAD77EF.
REQ-038 Fault cases:
- SW at 0x22 -> ack, fault=1, and a later LW 0x20 returns the prior contents unchanged.
- LH at 0x21 -> fault=1, rdata=0.
- funct3=011 load -> fault=1.
- funct3=100 with we=1 -> fault=1.
REQ-039 Reset cases:
- Assert rst mid-cycle after an accepted LW -> ack, fault and rdata drop to 0 at once and no ack pulse follows.
- req with rst=1 -> no write, verified by a readback after reset.
REQ-040 Random back-to-back load/store stream of 10k operations against a byte-array reference model -> every ack arrives at exactly one-cycle latency and matches the model's data and fault.
